// File: rtl/stage_tl.sv
// stage_tl: DTLB translation stage between execute (EXTL) and data cache (TLDC).
// Registers every EX field, translates ex_data through a small fully-associative
// DTLB (FIFO replacement, dedupe on write) and installs entries on dtlb tlbwrites.
// Ports: clk/rst (sync, active-high); ex_* instruction fields from EX; vm_enable
// selects translation; stall holds all state; flush bubbles the incoming op;
// dc_* registered pass-through plus dc_paddr and dc_dtlb_miss to the cache stage.
module stage_tl #(
   parameter int ENTRIES   = 4,
   parameter int PAGE_BITS = 12,
   parameter int PADDR_W   = 20,
   parameter int VADDR_W   = 32,
   parameter int THREAD_W  = 2,
   parameter int REG_W     = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [THREAD_W-1:0] ex_thread,
   input  logic                ex_isvalid,
   input  logic                ex_itlb_miss,
   input  logic [VADDR_W-1:0]  ex_pc,
   input  logic [VADDR_W-1:0]  ex_data,
   input  logic [VADDR_W-1:0]  ex_mul,
   input  logic [VADDR_W-1:0]  ex_r2,
   input  logic [REG_W-1:0]    ex_dst,
   input  logic                ex_isequal,
   input  logic                ex_flag_mem,
   input  logic                ex_flag_store,
   input  logic                ex_flag_isbyte,
   input  logic                ex_flag_mul,
   input  logic                ex_flag_reg,
   input  logic                ex_flag_jump,
   input  logic                ex_flag_branch,
   input  logic                ex_flag_iret,
   input  logic [1:0]          ex_flag_tlbwrite,
   input  logic                vm_enable,
   input  logic                stall,
   input  logic                flush,
   output logic [THREAD_W-1:0] dc_thread,
   output logic                dc_isvalid,
   output logic                dc_itlb_miss,
   output logic [VADDR_W-1:0]  dc_pc,
   output logic [VADDR_W-1:0]  dc_data,
   output logic [VADDR_W-1:0]  dc_mul,
   output logic [VADDR_W-1:0]  dc_r2,
   output logic [REG_W-1:0]    dc_dst,
   output logic                dc_isequal,
   output logic                dc_flag_mem,
   output logic                dc_flag_store,
   output logic                dc_flag_isbyte,
   output logic                dc_flag_mul,
   output logic                dc_flag_reg,
   output logic                dc_flag_jump,
   output logic                dc_flag_branch,
   output logic                dc_flag_iret,
   output logic [1:0]          dc_flag_tlbwrite,
   output logic [PADDR_W-1:0]  dc_paddr,
   output logic                dc_dtlb_miss
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int VPN_W = VADDR_W - PAGE_BITS;
   localparam int PPN_W = PADDR_W - PAGE_BITS;
   localparam logic [1:0] TLBW_DTLB = 2'd2;
   logic [VPN_W-1:0]   tag_q [ENTRIES];
   logic [PPN_W-1:0]   ppn_q [ENTRIES];
   logic [ENTRIES-1:0] valid_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [VPN_W-1:0]   vpn;
   logic               hit;
   logic [PPN_W-1:0]   hit_ppn;
   logic [IDX_W-1:0]   hit_idx;
   logic [IDX_W-1:0]   wr_idx;
   logic               miss;
   logic               tlb_we;
   logic [PADDR_W-1:0] paddr;
   assign vpn = ex_data[VADDR_W-1:PAGE_BITS];
   // Writes dedupe on tag, so at most one entry can match.
   always_comb begin
      hit     = 1'b0;
      hit_ppn = '0;
      hit_idx = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (valid_q[i] && tag_q[i] == vpn) begin
            hit     = 1'b1;
            hit_ppn = ppn_q[i];
            hit_idx = IDX_W'(i);
         end
   end
   assign miss   = ex_isvalid & ex_flag_mem & vm_enable & ~hit;
   assign tlb_we = ex_isvalid & (ex_flag_tlbwrite == TLBW_DTLB) & ~stall & ~flush & ~rst;
   // A tlbwrite to an already-present tag overwrites in place; otherwise FIFO slot.
   assign wr_idx = hit ? hit_idx : ptr_q;
   assign paddr  = vm_enable ? {hit_ppn, ex_data[PAGE_BITS-1:0]} : ex_data[PADDR_W-1:0];
   always_ff @(posedge clk) begin
      if (tlb_we) begin
         tag_q[wr_idx] <= vpn;
         ppn_q[wr_idx] <= ex_r2[PADDR_W-1:PAGE_BITS];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q          <= '0;
         ptr_q            <= '0;
         dc_thread        <= '0;
         dc_isvalid       <= 1'b0;
         dc_itlb_miss     <= 1'b0;
         dc_pc            <= '0;
         dc_data          <= '0;
         dc_mul           <= '0;
         dc_r2            <= '0;
         dc_dst           <= '0;
         dc_isequal       <= 1'b0;
         dc_flag_mem      <= 1'b0;
         dc_flag_store    <= 1'b0;
         dc_flag_isbyte   <= 1'b0;
         dc_flag_mul      <= 1'b0;
         dc_flag_reg      <= 1'b0;
         dc_flag_jump     <= 1'b0;
         dc_flag_branch   <= 1'b0;
         dc_flag_iret     <= 1'b0;
         dc_flag_tlbwrite <= '0;
         dc_paddr         <= '0;
         dc_dtlb_miss     <= 1'b0;
      end else begin
         if (tlb_we) begin
            valid_q[wr_idx] <= 1'b1;
            if (!hit) ptr_q <= ptr_q + 1'b1;
         end
         if (!stall) begin
            dc_thread        <= ex_thread;
            dc_isvalid       <= ex_isvalid & ~flush;
            dc_itlb_miss     <= ex_itlb_miss;
            dc_pc            <= ex_pc;
            dc_data          <= ex_data;
            dc_mul           <= ex_mul;
            dc_r2            <= ex_r2;
            dc_dst           <= ex_dst;
            dc_isequal       <= ex_isequal;
            // A faulting access must not reach the cache.
            dc_flag_mem      <= ex_flag_mem & ~miss;
            dc_flag_store    <= ex_flag_store & ~miss;
            dc_flag_isbyte   <= ex_flag_isbyte;
            dc_flag_mul      <= ex_flag_mul;
            dc_flag_reg      <= ex_flag_reg;
            dc_flag_jump     <= ex_flag_jump;
            dc_flag_branch   <= ex_flag_branch;
            dc_flag_iret     <= ex_flag_iret;
            dc_flag_tlbwrite <= ex_flag_tlbwrite;
            dc_paddr         <= paddr;
            dc_dtlb_miss     <= miss & ~flush;
         end
      end
   end
endmodule

// File: tb/tb_stage_tl.sv
// tb_stage_tl: randomized and directed self-checking bench for stage_tl.
module tb_stage_tl;
   localparam int EN = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, ex_isvalid, ex_itlb_miss, ex_isequal, vm_enable, stall, flush;
   logic ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret;
   logic [1:0] ex_thread, ex_flag_tlbwrite;
   logic [31:0] ex_pc, ex_data, ex_mul, ex_r2;
   logic [4:0] ex_dst;
   logic dc_isvalid, dc_itlb_miss, dc_isequal, dc_dtlb_miss;
   logic dc_flag_mem, dc_flag_store, dc_flag_isbyte, dc_flag_mul, dc_flag_reg, dc_flag_jump, dc_flag_branch, dc_flag_iret;
   logic [1:0] dc_thread, dc_flag_tlbwrite;
   logic [31:0] dc_pc, dc_data, dc_mul, dc_r2;
   logic [4:0] dc_dst;
   logic [19:0] dc_paddr;
   stage_tl dut (
      .clk(clk), .rst(rst), .ex_thread(ex_thread), .ex_isvalid(ex_isvalid), .ex_itlb_miss(ex_itlb_miss),
      .ex_pc(ex_pc), .ex_data(ex_data), .ex_mul(ex_mul), .ex_r2(ex_r2), .ex_dst(ex_dst), .ex_isequal(ex_isequal),
      .ex_flag_mem(ex_flag_mem), .ex_flag_store(ex_flag_store), .ex_flag_isbyte(ex_flag_isbyte),
      .ex_flag_mul(ex_flag_mul), .ex_flag_reg(ex_flag_reg), .ex_flag_jump(ex_flag_jump),
      .ex_flag_branch(ex_flag_branch), .ex_flag_iret(ex_flag_iret), .ex_flag_tlbwrite(ex_flag_tlbwrite),
      .vm_enable(vm_enable), .stall(stall), .flush(flush),
      .dc_thread(dc_thread), .dc_isvalid(dc_isvalid), .dc_itlb_miss(dc_itlb_miss), .dc_pc(dc_pc),
      .dc_data(dc_data), .dc_mul(dc_mul), .dc_r2(dc_r2), .dc_dst(dc_dst), .dc_isequal(dc_isequal),
      .dc_flag_mem(dc_flag_mem), .dc_flag_store(dc_flag_store), .dc_flag_isbyte(dc_flag_isbyte),
      .dc_flag_mul(dc_flag_mul), .dc_flag_reg(dc_flag_reg), .dc_flag_jump(dc_flag_jump),
      .dc_flag_branch(dc_flag_branch), .dc_flag_iret(dc_flag_iret), .dc_flag_tlbwrite(dc_flag_tlbwrite),
      .dc_paddr(dc_paddr), .dc_dtlb_miss(dc_dtlb_miss)
   );
   int n_chk = 0, n_err = 0;
   // Reference DTLB: list of (vpn, ppn) mappings with oldest-first replacement.
   logic [19:0] m_vpn [EN];
   logic [7:0]  m_ppn [EN];
   bit          m_val [EN];
   int          m_ptr;
   logic e_valid, e_miss, e_mem, e_store;
   logic [19:0] e_paddr;
   logic [144:0] e_pass;
   bit e_skip, e_nopaddr;
   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [144:0] pass_in();
      return {ex_pc, ex_data, ex_mul, ex_r2, ex_dst, ex_thread, ex_isequal, ex_itlb_miss, ex_flag_isbyte,
              ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret, ex_flag_tlbwrite};
   endfunction
   function automatic logic [144:0] pass_out();
      return {dc_pc, dc_data, dc_mul, dc_r2, dc_dst, dc_thread, dc_isequal, dc_itlb_miss, dc_flag_isbyte,
              dc_flag_mul, dc_flag_reg, dc_flag_jump, dc_flag_branch, dc_flag_iret, dc_flag_tlbwrite};
   endfunction
   task automatic m_write(input logic [19:0] v, input logic [7:0] p);
      for (int i = 0; i < EN; i++)
         if (m_val[i] && m_vpn[i] == v) begin
            m_ppn[i] = p;
            return;
         end
      m_vpn[m_ptr] = v;
      m_ppn[m_ptr] = p;
      m_val[m_ptr] = 1;
      m_ptr = (m_ptr + 1) % EN;
   endtask
   // Predict from current inputs, clock once, then compare.
   task automatic tick();
      bit hit, raw_miss;
      logic [7:0] ppn;
      if (rst) begin
         for (int i = 0; i < EN; i++) m_val[i] = 0;
         m_ptr = 0;
         {e_valid, e_miss, e_mem, e_store, e_paddr, e_pass, e_skip, e_nopaddr} = '0;
      end else if (!stall) begin
         hit = 0;
         ppn = 0;
         for (int i = 0; i < EN; i++)
            if (m_val[i] && m_vpn[i] == ex_data[31:12]) begin
               hit = 1;
               ppn = m_ppn[i];
            end
         raw_miss  = ex_isvalid && ex_flag_mem && vm_enable && !hit;
         e_valid   = ex_isvalid && !flush;
         e_miss    = raw_miss && !flush;
         e_mem     = ex_flag_mem && !raw_miss;
         e_store   = ex_flag_store && !raw_miss;
         e_paddr   = vm_enable ? {ppn, ex_data[11:0]} : ex_data[19:0];
         e_nopaddr = raw_miss;
         e_pass    = pass_in();
         e_skip    = flush;
         if (ex_isvalid && ex_flag_tlbwrite == 2'd2 && !flush) m_write(ex_data[31:12], ex_r2[19:12]);
      end
      @(posedge clk);
      #1;
      chk("isvalid", 160'(dc_isvalid), 160'(e_valid));
      chk("dtlb_miss", 160'(dc_dtlb_miss), 160'(e_miss));
      if (!e_skip) begin
         chk("flag_mem", 160'(dc_flag_mem), 160'(e_mem));
         chk("flag_store", 160'(dc_flag_store), 160'(e_store));
         chk("passthru", 160'(pass_out()), 160'(e_pass));
         if (!e_nopaddr) chk("paddr", 160'(dc_paddr), 160'(e_paddr));
      end
   endtask
   task automatic nop();
      {rst, stall, flush, ex_isvalid, ex_itlb_miss, ex_isequal, ex_flag_mem, ex_flag_store, ex_flag_isbyte,
       ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret} = '0;
      {ex_thread, ex_flag_tlbwrite, ex_pc, ex_data, ex_mul, ex_r2, ex_dst} = '0;
      vm_enable = 1'b1;
   endtask
   task automatic load(input logic [31:0] a);
      nop();
      ex_isvalid  = 1'b1;
      ex_flag_mem = 1'b1;
      ex_data     = a;
      tick();
   endtask
   task automatic tlbw(input logic [31:0] v, input logic [31:0] p);
      nop();
      ex_isvalid       = 1'b1;
      ex_flag_tlbwrite = 2'd2;
      ex_data          = v;
      ex_r2            = p;
      tick();
   endtask
   task automatic do_reset();
      nop();
      rst = 1'b1;
      tick();
   endtask
   initial begin
      do_reset();
      chk("rst_pass", 160'(pass_out()), 160'(0));
      chk("rst_paddr", 160'(dc_paddr), 160'(0));
      load(32'h0000_3ABC);
      chk("t1_miss", 160'(dc_dtlb_miss), 160'(1));
      chk("t1_mem", 160'(dc_flag_mem), 160'(0));
      chk("t1_data", 160'(dc_data), 160'(32'h0000_3ABC));
      chk("t1_valid", 160'(dc_isvalid), 160'(1));
      tlbw(32'h0000_3000, 32'h0005_5000);
      load(32'h0000_3ABC);
      chk("t2_paddr", 160'(dc_paddr), 160'(20'h55ABC));
      chk("t2_miss", 160'(dc_dtlb_miss), 160'(0));
      // Stall while a tlbwrite and then a new load are presented.
      for (int c = 0; c < 3; c++) begin
         nop();
         stall = 1'b1;
         flush = 1'b1;
         ex_isvalid = 1'b1;
         if (c == 0) begin
            ex_flag_tlbwrite = 2'd2;
            ex_data = 32'h0000_9000;
            ex_r2 = 32'h0009_9000;
         end else begin
            ex_flag_mem = 1'b1;
            ex_data = 32'h0000_9123;
         end
         tick();
         chk("stall_paddr", 160'(dc_paddr), 160'(20'h55ABC));
      end
      load(32'h0000_9123);
      chk("post_stall_miss", 160'(dc_dtlb_miss), 160'(1));
      do_reset();
      for (int v = 1; v <= 5; v++) tlbw(32'(v) << 12, 32'(8'h10 + v) << 12);
      load(32'h0000_1004);
      chk("evict_vpn1", 160'(dc_dtlb_miss), 160'(1));
      load(32'h0000_5004);
      chk("hit_vpn5", 160'(dc_paddr), 160'(20'h15004));
      tlbw(32'h0000_3000, 32'h0007_7000);
      load(32'h0000_3FFF);
      chk("rewrite_vpn3", 160'(dc_paddr), 160'(20'h77FFF));
      tlbw(32'h0000_6000, 32'h0006_6000);
      load(32'h0000_2000);
      chk("ptr1_evicts_vpn2", 160'(dc_dtlb_miss), 160'(1));
      load(32'h0000_3001);
      chk("vpn3_kept", 160'(dc_paddr), 160'(20'h77001));
      nop();
      ex_isvalid = 1'b1;
      ex_flag_mem = 1'b1;
      ex_data = 32'h0000_A000;
      flush = 1'b1;
      tick();
      chk("flush_valid", 160'(dc_isvalid), 160'(0));
      chk("flush_miss", 160'(dc_dtlb_miss), 160'(0));
      nop();
      vm_enable = 1'b0;
      ex_isvalid = 1'b1;
      ex_flag_mem = 1'b1;
      ex_data = 32'hFFFF_1234;
      tick();
      chk("novm_paddr", 160'(dc_paddr), 160'(20'hF1234));
      chk("novm_miss", 160'(dc_dtlb_miss), 160'(0));
      for (int n = 0; n < 600; n++) begin
         rst              = ($urandom % 97) == 0;
         stall            = ($urandom % 6) == 0;
         flush            = ($urandom % 8) == 0;
         vm_enable        = ($urandom % 8) != 0;
         ex_isvalid       = ($urandom % 5) != 0;
         ex_thread        = 2'($urandom);
         ex_pc            = $urandom;
         ex_mul           = $urandom;
         ex_r2            = $urandom;
         ex_dst           = 5'($urandom);
         {ex_itlb_miss, ex_isequal, ex_flag_isbyte, ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch,
          ex_flag_iret} = 8'($urandom);
         ex_flag_tlbwrite = ($urandom % 3 == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
         ex_flag_mem      = (ex_flag_tlbwrite == 2'd0) && ($urandom % 2 == 0);
         ex_flag_store    = ex_flag_mem && ($urandom % 2 == 0);
         ex_data          = ($urandom % 10 == 0) ? $urandom : ((32'($urandom_range(0, 7)) << 12) | ($urandom & 32'hFFF));
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/stage_tl.md
Name: stage_tl

Overview:
- DTLB translation stage; the receiving end of the EXTL interface driven by the execute stage.
- Registers every EXTL field. For valid memory ops, translates the ALU result (virtual address) to a physical address through a small fully-associative DTLB. Installs DTLB entries on tlbwrite instructions.
- Drives the TLDC register interface to the data-cache stage.
- Supports stall (hold) and flush (bubble injection).

Parameters:
- ENTRIES, 4, number of DTLB entries (power of 2, ≥2)
- PAGE_BITS, 12, page offset width
- PADDR_W, 20, physical address width
- VADDR_W, 32, virtual address width (matches word_t/vptr_t)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ex_thread  in  threadid_t  thread id from EX
- ex_isvalid  in  1  instruction valid
- ex_itlb_miss  in  1  ITLB miss carried from fetch
- ex_pc  in  vptr_t  instruction pc
- ex_data  in  word_t  ALU result; virtual address for mem ops
- ex_mul  in  word_t  multiplier result
- ex_r2  in  word_t  store data / tlbwrite PPN source
- ex_dst  in  regid_t  destination register
- ex_isequal  in  1  branch compare result
- ex_flag_mem, ex_flag_store, ex_flag_isbyte, ex_flag_mul, ex_flag_reg, ex_flag_jump, ex_flag_branch, ex_flag_iret  in  1 each  control flags
- ex_flag_tlbwrite  in  tlbwrite_t  off/itlb/dtlb
- vm_enable  in  1  1 = translate; 0 = paddr is the low PADDR_W bits of the vaddr
- stall  in  1  downstream stall; hold all state
- flush  in  1  kill the instruction entering this cycle
- dc_thread, dc_pc, dc_data, dc_mul, dc_r2, dc_dst, dc_isequal, dc_itlb_miss, dc_flag_*  out  same widths  registered pass-through
- dc_isvalid  out  1  registered valid
- dc_paddr  out  PADDR_W  translated address
- dc_dtlb_miss  out  1  DTLB miss exception flag

Behaviour:
- Reset (rst=1 at posedge):
  - All entry valid bits = 0; replacement pointer = 0.
  - All dc_* outputs = 0; dc_flag_tlbwrite = off.
  - rst has priority over stall and flush.
- Latency: 1 cycle. Inputs sampled at posedge N appear on dc_* after posedge N. Lookup is combinational on ex_data and is registered with the instruction.
- Stall=1 (and rst=0):
  - Every dc_* register holds.
  - No DTLB write; pointer holds.
  - flush is ignored while stall=1.
- Flush=1, stall=0:
  - dc_isvalid <= 0 and dc_dtlb_miss <= 0; other fields are don't-care.
  - No DTLB write.
- Lookup:
  - vpn = ex_data[VADDR_W-1:PAGE_BITS].
  - Hit when some valid entry has a matching tag; at most one entry can match, because writes dedupe.
  - dc_paddr <= {ppn, ex_data[PAGE_BITS-1:0]}.
- vm_enable=0: dc_paddr <= ex_data[PADDR_W-1:0]; dc_dtlb_miss <= 0.
- Miss: condition is ex_isvalid & ex_flag_mem & vm_enable & no hit. Then:
  - dc_dtlb_miss <= 1 and dc_flag_mem <= 0 (the cache must not access).
  - dc_flag_store <= 0.
  - dc_data keeps the faulting vaddr; dc_isvalid stays 1 so the exception reaches commit.
- Non-mem instructions never raise dc_dtlb_miss.
- DTLB write: condition is ex_isvalid & ex_flag_tlbwrite==dtlb & !stall & !flush.
  - Tag = ex_data[VADDR_W-1:PAGE_BITS]; PPN = ex_r2[PADDR_W-1:PAGE_BITS].
  - If the tag is already present and valid, overwrite that entry in place; the pointer does not advance.
  - Otherwise write entry[pointer] and set its valid bit; pointer <= (pointer+1) mod ENTRIES, wrapping ENTRIES-1 -> 0.
  - Takes effect at the posedge and is visible to the lookup of the next instruction. The tlbwrite instruction itself performs no translation (its ex_flag_mem is 0).
- ex_flag_tlbwrite == itlb: passes through to dc_flag_tlbwrite unchanged; DTLB unaffected. All tlbwrite values pass through.
- ex_isvalid=0: no write, no miss; fields are registered as-is.

Test Plan:
- Reset, then a load with vm_enable=1 and ex_data=0x00003ABC → dc_dtlb_miss=1, dc_flag_mem=0, dc_data=0x00003ABC, dc_isvalid=1.
- dtlb write with ex_data=0x00003000, ex_r2=0x00055000; next cycle a load at 0x00003ABC → dc_paddr=0x55ABC, dc_dtlb_miss=0.
- Five distinct dtlb writes (vpn 1..5) with ENTRIES=4 → vpn1 is evicted (entry 0 rewritten), load at vpn1 misses, load at vpn5 hits; pointer=1.
- Rewrite vpn 3 with a new PPN 0x77 → the pointer does not advance; a load at vpn 3 yields PPN 0x77 and no duplicate entry exists.
- Hold stall=1 for 3 cycles while presenting a dtlb write and a new load → dc_* unchanged and no entry written; after stall drops, the load result appears 1 cycle later.
- Flush with a valid missing load → dc_isvalid=0, dc_dtlb_miss=0. vm_enable=0 load at 0xFFFF1234 → dc_paddr=0xF1234, no miss.
